// File: rtl/udp_tx_mux_100g.sv
// rtl/udp_tx_mux_100g.sv - packet-locked N:1 UDP TX stream mux with one output register stage
module udp_tx_mux_100g #(
    parameter int NUM_CHANNELS  = 4,
    parameter int DATA_WIDTH    = 512,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int CONN_ID_WIDTH = 18,
    parameter int ARB_MODE      = 0,
    localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                  tx_axis_aclk,
    input  logic                                  tx_axis_areset,
    input  logic [NUM_CHANNELS*CONN_ID_WIDTH-1:0] s_axis_connection_id,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_CHANNELS*KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [NUM_CHANNELS-1:0]               s_axis_tvalid,
    input  logic [NUM_CHANNELS-1:0]               s_axis_tlast,
    output logic [NUM_CHANNELS-1:0]               s_axis_tready,
    output logic [CONN_ID_WIDTH-1:0]              m_axis_connection_id,
    output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]                 m_axis_tkeep,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    input  logic                                  m_axis_tready,
    output logic [CH_W-1:0]                       m_axis_tdest,
    output logic                                  busy
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state;
    logic [CH_W-1:0] grant;
    logic [CH_W-1:0] last_grant;
    logic [CH_W-1:0] pick;
    logic            first_beat;
    logic            out_free;
    logic            accept;
    logic            found;
    int              idx;

    // Output register can take a new beat when empty or being drained this cycle
    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign accept   = (state == XFER) && s_axis_tvalid[grant] && out_free;
    assign busy     = (state == XFER);

    // Only the locked channel sees ready, and only while a packet is granted
    always_comb begin
        s_axis_tready = '0;
        if (state == XFER) begin
            s_axis_tready[grant] = out_free;
        end
    end

    // Arbiter: fixed priority (lowest index) or round-robin starting after last_grant
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        idx   = 0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
                if (s_axis_tvalid[i]) begin
                    pick = CH_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= NUM_CHANNELS; k++) begin
                idx = (int'(last_grant) + k) % NUM_CHANNELS;
                if (!found && s_axis_tvalid[idx]) begin
                    pick  = CH_W'(idx);
                    found = 1'b1;
                end
            end
        end
    end

    // Packet-level FSM: grant in IDLE, hold the lock in XFER until tlast is accepted
    always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
        if (tx_axis_areset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CH_W'(NUM_CHANNELS - 1);
            first_beat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant      <= pick;
                        last_grant <= pick;
                        first_beat <= 1'b1;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        first_beat <= 1'b0;
                        if (s_axis_tlast[grant]) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single output register; beat fields frozen while stalled, connection ID latched on first beat
    always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
        if (tx_axis_areset) begin
            m_axis_tvalid        <= 1'b0;
            m_axis_tlast         <= 1'b0;
            m_axis_tdata         <= '0;
            m_axis_tkeep         <= '0;
            m_axis_tdest         <= '0;
            m_axis_connection_id <= '0;
        end else if (out_free) begin
            m_axis_tvalid <= accept;
            if (accept) begin
                m_axis_tdata <= s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                m_axis_tkeep <= s_axis_tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH];
                m_axis_tlast <= s_axis_tlast[grant];
                m_axis_tdest <= grant;
                if (first_beat) begin
                    m_axis_connection_id <= s_axis_connection_id[int'(grant)*CONN_ID_WIDTH +: CONN_ID_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_mux_100g.sv
// tb/tb_udp_tx_mux_100g.sv - directed self-checking bench for udp_tx_mux_100g
module tb_udp_tx_mux_100g;

    localparam int NC = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int IW = 18;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [1:0]    dest;
        logic [IW-1:0] id;
    } obeat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // round-robin instance signals
    logic [NC*IW-1:0] s_id     = '0;
    logic [NC*DW-1:0] s_tdata  = '0;
    logic [NC*KW-1:0] s_tkeep  = '0;
    logic [NC-1:0]    s_tvalid = '0;
    logic [NC-1:0]    s_tlast  = '0;
    logic [NC-1:0]    s_tready;
    logic [IW-1:0]    m_id;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tready = 1'b1;
    logic [1:0]       m_tdest;
    logic             busy;

    // fixed-priority instance signals
    logic [NC*IW-1:0] fp_id     = {18'h00F03, 18'h00F02, 18'h00F01, 18'h00F00};
    logic [NC*DW-1:0] fp_tdata  = {64'd3, 64'd2, 64'd1, 64'd0};
    logic [NC*KW-1:0] fp_tkeep  = '1;
    logic [NC-1:0]    fp_tvalid = '0;
    logic [NC-1:0]    fp_tlast  = '1;
    logic [NC-1:0]    fp_tready;
    logic [IW-1:0]    fp_m_id;
    logic [DW-1:0]    fp_m_tdata;
    logic [KW-1:0]    fp_m_tkeep;
    logic             fp_m_tvalid;
    logic             fp_m_tlast;
    logic             fp_m_tready = 1'b1;
    logic [1:0]       fp_m_tdest;
    logic             fp_busy;

    udp_tx_mux_100g #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
                      .CONN_ID_WIDTH(IW), .ARB_MODE(0)) dut_rr (
        .tx_axis_aclk(clk), .tx_axis_areset(rst),
        .s_axis_connection_id(s_id), .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_connection_id(m_id), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .m_axis_tdest(m_tdest), .busy(busy)
    );

    udp_tx_mux_100g #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
                      .CONN_ID_WIDTH(IW), .ARB_MODE(1)) dut_fp (
        .tx_axis_aclk(clk), .tx_axis_areset(rst),
        .s_axis_connection_id(fp_id), .s_axis_tdata(fp_tdata), .s_axis_tkeep(fp_tkeep),
        .s_axis_tvalid(fp_tvalid), .s_axis_tlast(fp_tlast), .s_axis_tready(fp_tready),
        .m_axis_connection_id(fp_m_id), .m_axis_tdata(fp_m_tdata), .m_axis_tkeep(fp_m_tkeep),
        .m_axis_tvalid(fp_m_tvalid), .m_axis_tlast(fp_m_tlast), .m_axis_tready(fp_m_tready),
        .m_axis_tdest(fp_m_tdest), .busy(fp_busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic bp_mode = 1'b0;

    beat_t         src_q [NC][$];
    logic [IW-1:0] src_id [NC];
    obeat_t        out_q [$];
    logic [NC-1:0] s_fire_s = '0;
    logic          m_fire_s = 1'b0;
    obeat_t        m_snap;

    function automatic logic [DW-1:0] mk(input int ch, input int n);
        return {32'(ch), 32'(n)};
    endfunction

    // sample handshakes mid-cycle, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            s_fire_s = s_tvalid & s_tready;
            m_fire_s = m_tvalid && m_tready;
            m_snap   = '{m_tdata, m_tkeep, m_tlast, m_tdest, m_id};
        end
    end

    // source queues and output collector, updated at each edge then inputs re-driven
    initial begin
        for (int i = 0; i < NC; i++) src_id[i] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                for (int i = 0; i < NC; i++) src_q[i].delete();
                s_fire_s = '0;
                m_fire_s = 1'b0;
            end else begin
                if (m_fire_s) out_q.push_back(m_snap);
                for (int i = 0; i < NC; i++)
                    if (s_fire_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            #1;
            for (int i = 0; i < NC; i++) begin
                s_id[i*IW +: IW] = src_id[i];
                if (src_q[i].size() > 0) begin
                    s_tvalid[i]         = 1'b1;
                    s_tdata[i*DW +: DW] = src_q[i][0].data;
                    s_tkeep[i*KW +: KW] = src_q[i][0].keep;
                    s_tlast[i]          = src_q[i][0].last;
                end else begin
                    s_tvalid[i] = 1'b0;
                    s_tlast[i]  = 1'b0;
                end
            end
            m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_pkt(input int ch, input int n, input logic [IW-1:0] id, input int base);
        beat_t b;
        src_id[ch] = id;
        for (int j = 0; j < n; j++) begin
            b.data = mk(ch, base + j);
            b.keep = (j == n - 1) ? 8'h07 : 8'hFF;
            b.last = (j == n - 1);
            src_q[ch].push_back(b);
        end
    endtask

    task automatic wait_out(input int n, input int budget, input string tag);
        int k = 0;
        while (out_q.size() < n && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        n_cmp++;
        if (out_q.size() < n) begin
            n_err++;
            $display("FAIL %s beat count: got %0d required %0d", tag, out_q.size(), n);
        end
    endtask

    task automatic check_beat(input string tag, input int ch, input int n_idx,
                              input logic [KW-1:0] keep, input logic last, input logic [IW-1:0] id);
        obeat_t o;
        if (out_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s missing beat: got none required ch%0d idx%0d", tag, ch, n_idx);
            return;
        end
        o = out_q.pop_front();
        n_cmp++;
        if (o.data !== mk(ch, n_idx) || o.dest !== 2'(ch) || o.keep !== keep ||
            o.last !== last || o.id !== id) begin
            n_err++;
            $display("FAIL %s beat: got data=%h dest=%0d keep=%h last=%b id=%h required data=%h dest=%0d keep=%h last=%b id=%h",
                     tag, o.data, o.dest, o.keep, o.last, o.id, mk(ch, n_idx), ch, keep, last, id);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        out_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_cmp++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0 ||
            m_id !== '0 || m_tdest !== '0 || s_tready !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rr: got vld=%b last=%b data=%h keep=%h id=%h dest=%0d rdy=%b busy=%b required all zero",
                     m_tvalid, m_tlast, m_tdata, m_tkeep, m_id, m_tdest, s_tready, busy);
        end
        n_cmp++;
        if (fp_m_tvalid !== 1'b0 || fp_tready !== '0 || fp_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_fp: got vld=%b rdy=%b busy=%b required 0/0/0", fp_m_tvalid, fp_tready, fp_busy);
        end
        do_reset();
    endtask

    task automatic test_single();
        int t0 = -1;
        int t1 = -1;
        @(posedge clk);
        #2;
        push_pkt(2, 3, 18'h001A5, 0);
        for (int k = 0; k < 20 && t1 < 0; k++) begin
            @(negedge clk);
            if (t0 < 0 && s_tvalid[2]) t0 = cyc;
            if (t0 >= 0 && cyc == t0 + 1) begin
                n_cmp++;
                if (busy !== 1'b1 || s_tready !== 4'b0100) begin
                    n_err++;
                    $display("FAIL single_grant: got busy=%b rdy=%b required 1/0100", busy, s_tready);
                end
            end
            if (t1 < 0 && m_tvalid) t1 = cyc;
        end
        n_cmp++;
        if (t0 < 0 || t1 < 0 || t1 - t0 != 2) begin
            n_err++;
            $display("FAIL single_latency: got %0d cycles required 2", t1 - t0);
        end
        wait_out(3, 30, "single");
        check_beat("single_b0", 2, 0, 8'hFF, 1'b0, 18'h001A5);
        check_beat("single_b1", 2, 1, 8'hFF, 1'b0, 18'h001A5);
        check_beat("single_b2", 2, 2, 8'h07, 1'b1, 18'h001A5);
    endtask

    task automatic test_round_robin();
        do_reset();
        @(posedge clk);
        #2;
        for (int ch = 0; ch < NC; ch++) begin
            push_pkt(ch, 1, 18'(32'h100 + ch), 0);
            push_pkt(ch, 1, 18'(32'h100 + ch), 1);
        end
        wait_out(8, 60, "rr");
        for (int r = 0; r < 2; r++)
            for (int ch = 0; ch < NC; ch++)
                check_beat("rr_order", ch, r, 8'h07, 1'b1, 18'(32'h100 + ch));
    endtask

    task automatic test_backpressure();
        obeat_t prev;
        logic   prev_stall = 1'b0;
        int     k = 0;
        bp_mode = 1'b1;
        @(posedge clk);
        #2;
        push_pkt(1, 8, 18'h3ABCD, 0);
        while (out_q.size() < 8 && k < 300) begin
            @(negedge clk);
            k++;
            if (prev_stall) begin
                n_cmp++;
                if (m_tvalid !== 1'b1 || m_tdata !== prev.data || m_tkeep !== prev.keep ||
                    m_tlast !== prev.last || m_tdest !== prev.dest) begin
                    n_err++;
                    $display("FAIL bp_stable: got vld=%b data=%h last=%b required vld=1 data=%h last=%b",
                             m_tvalid, m_tdata, m_tlast, prev.data, prev.last);
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev       = '{m_tdata, m_tkeep, m_tlast, m_tdest, m_id};
        end
        bp_mode = 1'b0;
        wait_out(8, 10, "bp");
        for (int j = 0; j < 8; j++)
            check_beat("bp_payload", 1, j, (j == 7) ? 8'h07 : 8'hFF, (j == 7), 18'h3ABCD);
    endtask

    task automatic test_lock();
        int  k = 0;
        logic done = 1'b0;
        @(posedge clk);
        #2;
        push_pkt(1, 6, 18'h00011, 16);
        while (!m_tvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #2;
        push_pkt(0, 1, 18'h00022, 32);
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
            n_cmp++;
            if (s_tready[0] !== 1'b0) begin
                n_err++;
                $display("FAIL lock_ch0_ready: got %b required 0", s_tready[0]);
            end
            if (s_tvalid[1] && s_tready[1] && s_tlast[1]) done = 1'b1;
        end
        wait_out(7, 30, "lock");
        for (int j = 0; j < 6; j++)
            check_beat("lock_ch1", 1, 16 + j, (j == 5) ? 8'h07 : 8'hFF, (j == 5), 18'h00011);
        check_beat("lock_ch0", 0, 32, 8'h07, 1'b1, 18'h00022);
    endtask

    task automatic test_fixed_priority();
        int beats = 0;
        int got = 0;
        int k = 0;
        logic [1:0]    d [2];
        logic [DW-1:0] dd [2];
        @(posedge clk);
        #1;
        fp_tvalid = 4'b1001;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            n_cmp++;
            if (fp_tready[3] !== 1'b0) begin
                n_err++;
                $display("FAIL fp_starve_ready: got %b required 0", fp_tready[3]);
            end
            if (fp_m_tvalid) begin
                beats++;
                n_cmp++;
                if (fp_m_tdest !== 2'd0) begin
                    n_err++;
                    $display("FAIL fp_dest: got %0d required 0", fp_m_tdest);
                end
            end
        end
        n_cmp++;
        if (beats < 8) begin
            n_err++;
            $display("FAIL fp_beats: got %0d required at least 8", beats);
        end
        while (fp_tready[0] !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        fp_tvalid = 4'b1000;
        for (int j = 0; j < 10 && got < 2; j++) begin
            @(negedge clk);
            if (fp_m_tvalid) begin
                d[got]  = fp_m_tdest;
                dd[got] = fp_m_tdata;
                got++;
            end
        end
        n_cmp++;
        if (got != 2 || d[0] !== 2'd0 || d[1] !== 2'd3 || dd[1] !== 64'd3 || fp_m_id !== 18'h00F03) begin
            n_err++;
            $display("FAIL fp_handover: got n=%0d dest0=%0d dest1=%0d data1=%h id=%h required 2/0/3/3/00f03",
                     got, d[0], d[1], dd[1], fp_m_id);
        end
        fp_tvalid = 4'b0000;
    endtask

    task automatic test_reset_mid();
        int k = 0;
        @(posedge clk);
        #2;
        push_pkt(3, 4, 18'h30003, 48);
        while (!(m_tvalid && m_tdata === mk(3, 49)) && k < 30) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (!(m_tvalid && m_tdata === mk(3, 49))) begin
            n_err++;
            $display("FAIL rstmid_beat2: got vld=%b data=%h required 1/%h", m_tvalid, m_tdata, mk(3, 49));
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || m_tdest !== '0 ||
            m_id !== '0 || s_tready !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_async: got vld=%b last=%b data=%h dest=%0d id=%h rdy=%b busy=%b required all zero",
                     m_tvalid, m_tlast, m_tdata, m_tdest, m_id, s_tready, busy);
        end
        do_reset();
        @(posedge clk);
        #2;
        push_pkt(0, 2, 18'h00777, 64);
        wait_out(2, 30, "rstmid");
        repeat (10) @(posedge clk);
        #2;
        n_cmp++;
        if (out_q.size() != 2) begin
            n_err++;
            $display("FAIL rstmid_residue: got %0d beats required 2", out_q.size());
        end
        check_beat("rstmid_b0", 0, 64, 8'hFF, 1'b0, 18'h00777);
        check_beat("rstmid_b1", 0, 65, 8'h07, 1'b1, 18'h00777);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_lock();
        test_fixed_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
